// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word.
// Two-stage valid/ready pipeline. Stage 1 registers the request and its
// immediate checks, stage 2 packs the word (or substitutes the NOP on error).
module instr_encoder #(
    parameter int unsigned CNT_W    = 16,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       fmt,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [2:0] FmtR = 3'd0;
    localparam logic [2:0] FmtI = 3'd1;
    localparam logic [2:0] FmtS = 3'd2;
    localparam logic [2:0] FmtB = 3'd3;
    localparam logic [2:0] FmtU = 3'd4;
    localparam logic [2:0] FmtJ = 3'd5;

    localparam logic [1:0] ErrNone  = 2'd0;
    localparam logic [1:0] ErrRange = 2'd1;
    localparam logic [1:0] ErrAlign = 2'd2;
    localparam logic [1:0] ErrFmt   = 2'd3;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    // Stage 1 state
    logic        s1_valid_q;
    logic [2:0]  s1_fmt_q;
    logic [6:0]  s1_opcode_q;
    logic [4:0]  s1_rd_q;
    logic [4:0]  s1_rs1_q;
    logic [4:0]  s1_rs2_q;
    logic [2:0]  s1_funct3_q;
    logic [6:0]  s1_funct7_q;
    logic [31:0] s1_imm_q;
    logic [1:0]  s1_code_q;

    // Stage 2 state
    logic        s2_valid_q;
    logic [31:0] s2_instr_q;
    logic        s2_err_q;
    logic [1:0]  s2_code_q;

    logic [CNT_W-1:0] enc_count_q;
    logic [CNT_W-1:0] err_count_q;

    logic        s2_load;
    logic        s1_load;
    logic        accept;
    logic [1:0]  chk_code;
    logic [31:0] packed_word;

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;
    assign accept   = in_valid && in_ready;

    assign out_valid = s2_valid_q;
    assign instr     = s2_instr_q;
    assign err       = s2_err_q;
    assign err_code  = s2_code_q;
    assign enc_count = enc_count_q;
    assign err_count = err_count_q;

    // Immediate range / alignment / format checks on the incoming request
    always_comb begin
        chk_code = ErrNone;
        case (fmt)
            FmtR: chk_code = ErrNone;
            FmtI, FmtS: begin
                if (!((&imm[31:11]) || !(|imm[31:11]))) chk_code = ErrRange;
            end
            FmtB: begin
                if (!((&imm[31:12]) || !(|imm[31:12]))) chk_code = ErrRange;
                else if (imm[0])                        chk_code = ErrAlign;
            end
            FmtJ: begin
                if (!((&imm[31:20]) || !(|imm[31:20]))) chk_code = ErrRange;
                else if (imm[0])                        chk_code = ErrAlign;
            end
            FmtU: begin
                if (|imm[11:0]) chk_code = ErrAlign;
            end
            default: chk_code = ErrFmt;
        endcase
    end

    // Pack the stage-1 fields into the final instruction word
    always_comb begin
        packed_word = 32'h0;
        case (s1_fmt_q)
            FmtR: packed_word = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q,
                                 s1_opcode_q};
            FmtI: packed_word = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
            FmtS: packed_word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                                 s1_imm_q[4:0], s1_opcode_q};
            FmtB: packed_word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                                 s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
            FmtU: packed_word = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
            FmtJ: packed_word = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                                 s1_rd_q, s1_opcode_q};
            default: packed_word = 32'h0;
        endcase
        if (s1_code_q != ErrNone) packed_word = NOP_WORD;
    end

    // Stage 1 register: fields only sampled on an input handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_fmt_q    <= 3'd0;
            s1_opcode_q <= 7'd0;
            s1_rd_q     <= 5'd0;
            s1_rs1_q    <= 5'd0;
            s1_rs2_q    <= 5'd0;
            s1_funct3_q <= 3'd0;
            s1_funct7_q <= 7'd0;
            s1_imm_q    <= 32'd0;
            s1_code_q   <= ErrNone;
        end else begin
            if (s1_load) s1_valid_q <= in_valid;
            if (accept) begin
                s1_fmt_q    <= fmt;
                s1_opcode_q <= opcode;
                s1_rd_q     <= rd;
                s1_rs1_q    <= rs1;
                s1_rs2_q    <= rs2;
                s1_funct3_q <= funct3;
                s1_funct7_q <= funct7;
                s1_imm_q    <= imm;
                s1_code_q   <= chk_code;
            end
        end
    end

    // Stage 2 register: output word held stable while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_instr_q <= 32'h0;
            s2_err_q   <= 1'b0;
            s2_code_q  <= ErrNone;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_instr_q <= packed_word;
                s2_err_q   <= (s1_code_q != ErrNone);
                s2_code_q  <= s1_code_q;
            end
        end
    end

    // Saturating counters advance on the output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            enc_count_q <= '0;
            err_count_q <= '0;
        end else if (s2_valid_q && out_ready) begin
            if (s2_err_q) begin
                if (err_count_q != '1) err_count_q <= err_count_q + CntOne;
            end else begin
                if (enc_count_q != '1) enc_count_q <= enc_count_q + CntOne;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder with a reference model and scoreboard.
module tb_instr_encoder;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } req_t;

    typedef struct packed {
        logic        err;
        logic [1:0]  code;
        logic [31:0] instr;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  fmt = '0;
    logic [6:0]  opcode = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] instr;
    logic        err;
    logic [1:0]  err_code;
    logic [3:0]  enc_count;
    logic [3:0]  err_count;

    int n_cmp = 0;
    int n_bad = 0;
    req_t reqq[$];
    res_t expq[$];
    int inflight = 0;

    instr_encoder #(.CNT_W(4), .NOP_WORD(32'h0000_0013)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
        .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .instr(instr), .err(err),
        .err_code(err_code), .enc_count(enc_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic req_t mk(input logic [2:0] f, input logic [6:0] o, input logic [4:0] d,
                                input logic [4:0] a, input logic [4:0] b, input logic [2:0] f3v,
                                input logic [6:0] f7v, input logic [31:0] i);
        req_t r;
        r.fmt = f; r.opc = o; r.rd = d; r.rs1 = a; r.rs2 = b; r.f3 = f3v; r.f7 = f7v; r.imm = i;
        return r;
    endfunction

    // Reference encoder built from signed ranges and per-bit field placement
    function automatic res_t model(input req_t r);
        res_t x;
        logic [31:0] w;
        int si;
        si = $signed(r.imm);
        x.code = 2'd0;
        if (r.fmt > 3'd5) x.code = 2'd3;
        else if ((r.fmt == 3'd1 || r.fmt == 3'd2) && (si < -2048 || si > 2047)) x.code = 2'd1;
        else if (r.fmt == 3'd3 && (si < -4096 || si > 4095)) x.code = 2'd1;
        else if (r.fmt == 3'd5 && (si < -1048576 || si > 1048575)) x.code = 2'd1;
        else if ((r.fmt == 3'd3 || r.fmt == 3'd5) && r.imm[0]) x.code = 2'd2;
        else if (r.fmt == 3'd4 && r.imm[11:0] != 12'd0) x.code = 2'd2;
        w = 32'd0;
        w[6:0] = r.opc;
        case (r.fmt)
            3'd0: begin
                w[11:7] = r.rd; w[14:12] = r.f3; w[19:15] = r.rs1; w[24:20] = r.rs2;
                w[31:25] = r.f7;
            end
            3'd1: begin
                w[11:7] = r.rd; w[14:12] = r.f3; w[19:15] = r.rs1; w[31:20] = r.imm[11:0];
            end
            3'd2: begin
                w[11:7] = r.imm[4:0]; w[14:12] = r.f3; w[19:15] = r.rs1; w[24:20] = r.rs2;
                w[31:25] = r.imm[11:5];
            end
            3'd3: begin
                w[7] = r.imm[11]; w[11:8] = r.imm[4:1]; w[14:12] = r.f3; w[19:15] = r.rs1;
                w[24:20] = r.rs2; w[30:25] = r.imm[10:5]; w[31] = r.imm[12];
            end
            3'd4: begin
                w[11:7] = r.rd; w[31:12] = r.imm[31:12];
            end
            3'd5: begin
                w[11:7] = r.rd; w[19:12] = r.imm[19:12]; w[20] = r.imm[11];
                w[30:21] = r.imm[10:1]; w[31] = r.imm[20];
            end
            default: w = 32'd0;
        endcase
        x.err = (x.code != 2'd0);
        x.instr = x.err ? 32'h0000_0013 : w;
        return x;
    endfunction

    task automatic drive(input req_t r);
        fmt = r.fmt; opcode = r.opc; rd = r.rd; rs1 = r.rs1; rs2 = r.rs2;
        funct3 = r.f3; funct7 = r.f7; imm = r.imm;
    endtask

    // One clock of stimulus: present queue head, sample at negedge, push expected on accept
    task automatic cycle(input logic ordy, output logic got, output res_t o,
                         output logic ir, output logic ov);
        logic acc;
        if (reqq.size() > 0) begin
            in_valid = 1'b1;
            drive(reqq[0]);
        end else begin
            in_valid = 1'b0;
        end
        out_ready = ordy;
        @(negedge clk);
        ir = in_ready;
        ov = out_valid;
        o.err = err; o.code = err_code; o.instr = instr;
        got = out_valid && out_ready;
        acc = in_valid && in_ready;
        if (acc) begin
            expq.push_back(model(reqq[0]));
            void'(reqq.pop_front());
        end
        inflight = inflight + (acc ? 1 : 0) - (got ? 1 : 0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL rst_instr got %h want 0", instr); end
        n_cmp++; if ({err, err_code} !== 3'b000) begin n_bad++; $display("FAIL rst_err got %b%b want 000", err, err_code); end
        n_cmp++; if ({enc_count, err_count} !== 8'h00) begin n_bad++; $display("FAIL rst_counts got %h/%h want 0/0", enc_count, err_count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_encode;
        logic got, ir, ov;
        res_t o, e;
        logic [31:0] known[3];
        int k;
        known[0] = 32'hFE00_0EE3; known[1] = 32'h0080_00EF; known[2] = 32'h1234_52B7;
        // Manual two-cycle latency check on the first request
        drive(mk(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5));
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL lat_in_ready got %b want 1", in_ready); end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_early got %b want 0", out_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL lat_valid got %b want 1", out_valid); end
        n_cmp++; if ({err, instr} !== {1'b0, 32'h0050_0093}) begin n_bad++; $display("FAIL addi_word got %b %h want 0 00500093", err, instr); end
        @(posedge clk); #1;
        reqq.push_back(mk(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC));
        reqq.push_back(mk(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8));
        reqq.push_back(mk(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000));
        k = 0;
        for (int c = 0; c < 50 && (reqq.size() > 0 || expq.size() > 0); c++) begin
            cycle(1'b1, got, o, ir, ov);
            if (got && expq.size() > 0) begin
                e = expq.pop_front();
                n_cmp++; if (o !== e) begin n_bad++; $display("FAIL enc_model got %h want %h", o, e); end
                if (k < 3) begin
                    n_cmp++; if (o.instr !== known[k]) begin n_bad++; $display("FAIL enc_known[%0d] got %h want %h", k, o.instr, known[k]); end
                end
                k++;
            end
        end
        n_cmp++; if (k !== 3) begin n_bad++; $display("FAIL enc_outputs got %0d want 3", k); end
    endtask

    task automatic test_errors;
        logic got, ir, ov;
        res_t o, e;
        logic [1:0] codes[3];
        int k;
        codes[0] = 2'd1; codes[1] = 2'd2; codes[2] = 2'd3;
        reqq.push_back(mk(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048));
        reqq.push_back(mk(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3));
        reqq.push_back(mk(3'd6, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0));
        k = 0;
        for (int c = 0; c < 50 && (reqq.size() > 0 || expq.size() > 0); c++) begin
            cycle(1'b1, got, o, ir, ov);
            if (got && expq.size() > 0) begin
                e = expq.pop_front();
                n_cmp++; if (o !== e) begin n_bad++; $display("FAIL err_model got %h want %h", o, e); end
                if (k < 3) begin
                    n_cmp++;
                    if ({o.err, o.code, o.instr} !== {1'b1, codes[k], 32'h13}) begin
                        n_bad++; $display("FAIL err_known[%0d] got %b %0d %h want 1 %0d 00000013", k, o.err, o.code, o.instr, codes[k]);
                    end
                end
                k++;
            end
        end
        n_cmp++; if (k !== 3) begin n_bad++; $display("FAIL err_outputs got %0d want 3", k); end
        n_cmp++; if ({enc_count, err_count} !== {4'd4, 4'd3}) begin n_bad++; $display("FAIL counts got enc=%0d err=%0d want 4/3", enc_count, err_count); end
    endtask

    task automatic test_back_to_back;
        logic got, ir, ov, ordy, prev_stall;
        res_t o, e, prev_o;
        int pre, k, si;
        logic [31:0] u;
        for (int i = 0; i < 10; i++) begin
            u = $urandom();
            case (i % 6)
                0: si = 0;
                1, 2: si = int'($urandom_range(0, 4095)) - 2048;
                3: si = (int'($urandom_range(0, 8191)) - 4096) & ~1;
                4: si = int'({u[31:12], 12'h000});
                default: si = (int'($urandom_range(0, 2097151)) - 1048576) & ~1;
            endcase
            u = $urandom();
            reqq.push_back(mk(3'(i % 6), u[6:0], u[11:7], u[16:12], u[21:17], u[24:22],
                              u[31:25], 32'(si)));
        end
        k = 0;
        prev_stall = 1'b0;
        prev_o = '0;
        for (int c = 0; c < 200 && (reqq.size() > 0 || expq.size() > 0); c++) begin
            ordy = 1'($urandom_range(0, 1));
            pre = inflight;
            cycle(ordy, got, o, ir, ov);
            n_cmp++;
            if (ir !== !(pre == 2 && !ordy)) begin
                n_bad++; $display("FAIL b2b_in_ready got %b want %b (inflight %0d)", ir, !(pre == 2 && !ordy), pre);
            end
            if (prev_stall && ov) begin
                n_cmp++; if (o !== prev_o) begin n_bad++; $display("FAIL b2b_stall_hold got %h want %h", o, prev_o); end
            end
            prev_stall = ov && !ordy;
            prev_o = o;
            if (got) begin
                if (expq.size() == 0) begin
                    n_cmp++; n_bad++; $display("FAIL b2b_extra got %h want none", o);
                end else begin
                    e = expq.pop_front();
                    n_cmp++; if (o !== e) begin n_bad++; $display("FAIL b2b_word[%0d] got %h want %h", k, o, e); end
                    k++;
                end
            end
        end
        n_cmp++; if (k !== 10) begin n_bad++; $display("FAIL b2b_count got %0d want 10", k); end
        n_cmp++; if (enc_count !== 4'd14) begin n_bad++; $display("FAIL b2b_enc got %0d want 14", enc_count); end
    endtask

    task automatic test_reset_midflight;
        logic got, ir, ov;
        res_t o;
        reqq.push_back(mk(3'd1, 7'b0010011, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd7));
        reqq.push_back(mk(3'd1, 7'b0010011, 5'd4, 5'd5, 5'd0, 3'd0, 7'd0, 32'd9));
        cycle(1'b0, got, o, ir, ov);
        cycle(1'b0, got, o, ir, ov);
        cycle(1'b0, got, o, ir, ov);
        n_cmp++; if ({ir, ov} !== 2'b01) begin n_bad++; $display("FAIL full_stall got ready=%b valid=%b want 0/1", ir, ov); end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        reqq.delete(); expq.delete(); inflight = 0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_valid got %b want 0", out_valid); end
        n_cmp++; if ({enc_count, err_count} !== 8'h00) begin n_bad++; $display("FAIL mrst_counts got %h/%h want 0/0", enc_count, err_count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mrst_in_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        drive(mk(3'd2, 7'b0100011, 5'd0, 5'd6, 5'd7, 3'd2, 7'd0, 32'hFFFF_FFF0));
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_early got %b want 0", out_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, err, instr} !== {2'b10, 32'hFE73_2823}) begin
            n_bad++; $display("FAIL mrst_word got %b %b %h want 1 0 fe732823", out_valid, err, instr);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation;
        logic got, ir, ov;
        res_t o, e;
        for (int i = 0; i < 20; i++)
            reqq.push_back(mk(3'd0, 7'b0110011, 5'(i), 5'(i + 1), 5'(i + 2), 3'(i), 7'h20, 32'd0));
        for (int c = 0; c < 100 && (reqq.size() > 0 || expq.size() > 0); c++) begin
            cycle(1'b1, got, o, ir, ov);
            if (got && expq.size() > 0) begin
                e = expq.pop_front();
                n_cmp++; if (o !== e) begin n_bad++; $display("FAIL sat_word got %h want %h", o, e); end
            end
        end
        n_cmp++; if (reqq.size() + expq.size() != 0) begin n_bad++; $display("FAIL sat_drain got %0d pending want 0", reqq.size() + expq.size()); end
        n_cmp++; if ({enc_count, err_count} !== {4'hF, 4'h0}) begin n_bad++; $display("FAIL sat_counts got %0d/%0d want 15/0", enc_count, err_count); end
    endtask

    initial begin
        test_reset();
        test_encode();
        test_errors();
        test_back_to_back();
        test_reset_midflight();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Packs decoded RISC-V RV32I fields (format, opcode, registers, functs, full 32-bit immediate) into a 32-bit instruction word. It is the inverse of the core's immediate extraction path. It feeds the test-program loader and self-check benches through a 2-stage valid/ready pipeline. Immediates that are out of range or misaligned are flagged and replaced by a canonical NOP. Running counts of encoded and rejected requests are kept.

Parameters:
CNT_W, 16, width of the saturating enc_count / err_count counters
NOP_WORD, 32'h00000013, word emitted on error (addi x0,x0,0)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
in_valid  in  1  request valid
in_ready  out  1  encoder can accept a request this cycle
fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
opcode  in  7  instr[6:0]
rd  in  5  destination register
rs1  in  5  source register 1
rs2  in  5  source register 2
funct3  in  3  funct3 field
funct7  in  7  funct7 field (R only)
imm  in  32  full signed byte-offset or value; U-format takes the already-shifted value (imm[11:0]=0)
out_valid  out  1  encoded word valid
out_ready  in  1  consumer accepts
instr  out  32  encoded instruction
err  out  1  request rejected; instr=NOP_WORD
err_code  out  2  0 none, 1 range, 2 misaligned, 3 illegal fmt
enc_count  out  CNT_W  accepted requests encoded without error, saturating
err_count  out  CNT_W  accepted requests rejected, saturating

Behaviour:
- Reset (rst=1 at a clk edge): both stage valids 0, out_valid=0, instr=0, err=0, err_code=0, counters 0. An in-flight request is dropped and not counted. in_ready=1 in the first cycle after reset.
- A transfer occurs on a cycle with valid&ready at the clk edge. Inputs are sampled only at an in_valid&in_ready edge.
- Stage 1 registers the fields and computes the checks:
  - I/S: range error unless imm[31:11] all equal.
  - B: range error unless imm[31:12] all equal; misaligned if imm[0]=1.
  - J: range error unless imm[31:20] all equal; misaligned if imm[0]=1.
  - U: misaligned if imm[11:0]!=0.
  - R: imm ignored, never errors.
  - fmt 6/7: illegal.
  - Priority: illegal > range > misaligned.
- Stage 2 packs the word:
  - R {funct7,rs2,rs1,funct3,rd,opcode}
  - I {imm[11:0],rs1,funct3,rd,opcode}
  - S {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
  - B {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
  - U {imm[31:12],rd,opcode}
  - J {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
  - If err: instr=NOP_WORD, err=1, err_code set.
- Latency: 2 cycles from the accept edge to out_valid=1. Throughput is 1 per cycle while out_ready=1.
- Pipeline flow control:
  - Stage advance: s2 loads when !s2_valid | out_ready. s1 loads when !s1_valid | s2 loads.
  - in_ready = !s1_valid | (!s2_valid | out_ready). This is combinational, with no dependency on in_valid.
  - Bubbles collapse: an empty stage always fills.
- Stall: while out_valid=1 and out_ready=0, instr/err/err_code are held stable and in_ready drops once s1 is occupied. There is no loss or duplication under any valid/ready pattern.
- Counters update on the output handshake (out_valid&out_ready): enc_count += !err, err_count += err. Both saturate at all-ones.
- Simultaneous input accept and output handshake in one cycle: both take effect.
- fmt values outside R are not checked against opcode; opcode is passed through verbatim.

Test Plan:
- fmt=I, opcode=0010011, rd=1, rs1=0, funct3=0, imm=5, out_ready=1 -> out_valid 2 cycles later, instr=0x00500093, err=0.
- fmt=B, opcode=1100011, rs1=0, rs2=0, funct3=0, imm=0xFFFFFFFC -> instr=0xFE000EE3. Then fmt=J, opcode=1101111, rd=1, imm=8 -> instr=0x008000EF. Then fmt=U, opcode=0110111, rd=5, imm=0x12345000 -> instr=0x123452B7.
- fmt=I, imm=2048 -> err=1, err_code=1, instr=0x00000013. fmt=B, imm=3 -> err_code=2. fmt=6 -> err_code=3. Final counts after these three errors and the four good words above: err_count=3, enc_count=4.
- Back-to-back stream of 10 requests with out_ready toggling pseudo-randomly -> all 10 words emitted in order, none dropped or duplicated, instr stable during stalls, in_ready=0 only when both stages are full and out_ready=0.
- Assert rst while both stages hold valid requests -> next cycle out_valid=0, counters=0, in_ready=1; a new request then completes normally with 2-cycle latency.
- Force counters near saturation (CNT_W=4 build), send 20 good requests -> enc_count holds at 15.
